uart_bar_bridge: RTL and testbench

Byte-level host bridge between the PCIe BAR register path and the SoC UART pins (io_uart_rx / io_uart_tx) on the FPGA build. Host writes bytes into a TX FIFO; an 8N1 serializer drives the SoC's UART RX line. A deserializer samples the SoC's UART TX line into an RX FIFO that the host reads. It replaces the raw single-bit UART pin mapping in the FPGA top level.

---
 rtl/uart_bar_bridge.sv | 333 +++++++++++++++++++++++++++++++++
 tb/tb_uart_bar_bridge.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bar_bridge.sv
// uart_bar_bridge: byte-level bridge between the PCIe BAR register path and
// the SoC UART pins. Host writes go into a TX FIFO drained by an 8N1
// serializer; an 8N1 deserializer fills an RX FIFO that the host reads.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   bar_addr/bar_wdata    BAR byte address and write data
//   bar_wen/bar_ren       one-cycle write/read strobes
//   bar_rdata             registered read data, valid the cycle after bar_ren
//   uart_rx_out           serial line to SoC io_uart_rx (idle high)
//   uart_tx_in            serial line from SoC io_uart_tx (asynchronous)
//   irq                   level interrupt: rx data pending or any sticky error
//
// Build option: define UART_LOOPBACK_EN to add CTRL bit1 loopback (serializer
// output feeds the deserializer and uart_rx_out is held high).
//
// Register map: 0x2000 TXDATA(W), 0x2004 RXDATA(R), 0x2008 STATUS(R),
// 0x200C CTRL(R/W). Other reads return 0xDEADBEEF.
module uart_bar_bridge #(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] bar_addr,
  input  logic [31:0] bar_wdata,
  input  logic        bar_wen,
  input  logic        bar_ren,
  output logic [31:0] bar_rdata,
  output logic        uart_rx_out,
  input  logic        uart_tx_in,
  output logic        irq
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLK_DIV / 2 - 1);

  localparam logic [31:0] ADDR_TXDATA = 32'h0000_2000;
  localparam logic [31:0] ADDR_RXDATA = 32'h0000_2004;
  localparam logic [31:0] ADDR_STATUS = 32'h0000_2008;
  localparam logic [31:0] ADDR_CTRL   = 32'h0000_200C;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START_CHK, RX_DATA, RX_STOP} rx_state_t;

  logic wr_txdata, wr_ctrl, rd_rxdata, sticky_clr;
  assign wr_txdata  = bar_wen && (bar_addr == ADDR_TXDATA);
  assign wr_ctrl    = bar_wen && (bar_addr == ADDR_CTRL);
  assign rd_rxdata  = bar_ren && (bar_addr == ADDR_RXDATA);
  assign sticky_clr = wr_ctrl && bar_wdata[0];

  wire unused_wdata = ^bar_wdata[31:8];

  // ---------------- TX FIFO ----------------
  logic [7:0]    tx_mem [FIFO_DEPTH];
  logic [AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [AW:0]   tx_count;
  logic          tx_full, tx_empty, tx_push, tx_pop;

  assign tx_full  = (tx_count == DEPTH_CNT);
  assign tx_empty = (tx_count == '0);
  // A pop in the same cycle frees the slot, so a write to a full FIFO that
  // coincides with a serializer pop is still accepted.
  assign tx_push  = wr_txdata && (!tx_full || tx_pop);

  // NOTE: FIFO storage has no reset; pointers and count alone define validity,
  // which keeps the array in plain RAM/LUT cells.
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= bar_wdata[7:0];
  end

  // NOTE: sequential state is always assigned with <= so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + AW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CNT_ONE;
        2'b01:   tx_count <= tx_count - CNT_ONE;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // ---------------- Serializer ----------------
  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_baud, tx_baud_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_line, tx_baud_done;

  assign tx_baud_done = (tx_baud == BAUD_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_baud  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_state_n;
      tx_baud  <= tx_baud_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // signal unassigned (which would infer a latch).
  always_comb begin
    tx_state_n = tx_state;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    tx_pop     = 1'b0;
    tx_baud_n  = tx_baud_done ? 16'd0 : tx_baud + 16'd1;
    case (tx_state)
      TX_IDLE: begin
        tx_baud_n = '0;
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = tx_mem[tx_rd_ptr];
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_baud_done) begin
          tx_bit_n   = '0;
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_baud_done) begin
          tx_shift_n = {1'b0, tx_shift[7:1]};
          tx_bit_n   = tx_bit + 3'd1;
          if (tx_bit == 3'd7) tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_baud_done) begin
          // Chain straight into the next start bit so frames stay 10 bits apart.
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_n = tx_mem[tx_rd_ptr];
            tx_state_n = TX_START;
          end else begin
            tx_state_n = TX_IDLE;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign tx_line = (tx_state == TX_START) ? 1'b0 :
                   (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;

  // ---------------- Loopback option ----------------
  logic loopback, rx_src;
`ifdef UART_LOOPBACK_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        loopback <= 1'b0;
    else if (wr_ctrl) loopback <= bar_wdata[1];
  end
  assign rx_src      = loopback ? tx_line : uart_tx_in;
  assign uart_rx_out = tx_line | loopback;
`else
  assign loopback    = 1'b0;
  assign rx_src      = uart_tx_in;
  assign uart_rx_out = tx_line;
`endif

  // ---------------- Deserializer ----------------
  // Synchronizer and edge history reset low: a line caught low mid-frame at
  // reset release cannot look like a falling edge until it has been high.
  logic rx_meta, rx_sync, rx_prev;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx_src;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_baud, rx_baud_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_push, frame_err_set;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      rx_baud  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_baud  <= rx_baud_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  always_comb begin
    rx_state_n    = rx_state;
    rx_bit_n      = rx_bit;
    rx_shift_n    = rx_shift;
    rx_baud_n     = rx_baud + 16'd1;
    rx_push       = 1'b0;
    frame_err_set = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        rx_baud_n = '0;
        if (rx_prev && !rx_sync) rx_state_n = RX_START_CHK;
      end
      RX_START_CHK: begin
        if (rx_baud == HALF_LAST) begin
          rx_baud_n  = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          rx_bit_n   = rx_bit + 3'd1;
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_baud == BAUD_LAST) begin
          rx_baud_n  = '0;
          // After a framing error the edge detector itself waits for the line
          // to return high before another start bit can be seen.
          rx_state_n = RX_IDLE;
          if (rx_sync) rx_push       = 1'b1;
          else         frame_err_set = 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [AW:0]   rx_count;
  logic          rx_full, rx_empty, rx_pop, rx_accept, overrun_set;

  assign rx_full     = (rx_count == DEPTH_CNT);
  assign rx_empty    = (rx_count == '0);
  assign rx_pop      = rd_rxdata && !rx_empty;
  assign rx_accept   = rx_push && (!rx_full || rx_pop);
  assign overrun_set = rx_push && !rx_accept;

  always_ff @(posedge clock) begin
    if (rx_accept) rx_mem[rx_wr_ptr] <= rx_shift;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_accept) rx_wr_ptr <= rx_wr_ptr + AW'(1);
      if (rx_pop)    rx_rd_ptr <= rx_rd_ptr + AW'(1);
      case ({rx_accept, rx_pop})
        2'b10:   rx_count <= rx_count + CNT_ONE;
        2'b01:   rx_count <= rx_count - CNT_ONE;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // ---------------- Sticky status, read path, interrupt ----------------
  logic rx_overrun, rx_frame_err, tx_overflow;

  // Set wins over a simultaneous clear so no event is lost.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
      tx_overflow  <= 1'b0;
    end else begin
      rx_overrun   <= overrun_set             | (rx_overrun   & ~sticky_clr);
      rx_frame_err <= frame_err_set           | (rx_frame_err & ~sticky_clr);
      tx_overflow  <= (wr_txdata && !tx_push) | (tx_overflow  & ~sticky_clr);
    end
  end

  logic [8:0]  rx_cnt_ext;
  logic [7:0]  rx_cnt_field;
  logic [31:0] rd_data;

  assign rx_cnt_ext   = 9'(rx_count);
  assign rx_cnt_field = rx_cnt_ext[8] ? 8'hFF : rx_cnt_ext[7:0];

  always_comb begin
    rd_data = 32'hDEAD_BEEF;
    case (bar_addr)
      ADDR_RXDATA: rd_data = rx_empty ? 32'h0 : {23'b0, 1'b1, rx_mem[rx_rd_ptr]};
      ADDR_STATUS: rd_data = {16'b0, rx_cnt_field, (tx_state != TX_IDLE), tx_overflow,
                              rx_frame_err, rx_overrun, rx_full, rx_empty, tx_empty, tx_full};
      ADDR_CTRL:   rd_data = {30'b0, loopback, 1'b0};
      default:     rd_data = 32'hDEAD_BEEF;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bar_rdata <= '0;
      irq       <= 1'b0;
    end else begin
      if (bar_ren) bar_rdata <= rd_data;
      irq <= !rx_empty | rx_overrun | rx_frame_err | tx_overflow;
    end
  end

endmodule

// File: tb/tb_uart_bar_bridge.sv
// Directed bench for uart_bar_bridge with CLK_DIV=8, FIFO_DEPTH=4.
module tb_uart_bar_bridge;

  localparam logic [31:0] TXDATA = 32'h2000;
  localparam logic [31:0] RXDATA = 32'h2004;
  localparam logic [31:0] STATUS = 32'h2008;
  localparam logic [31:0] CTRL   = 32'h200C;

  logic        clock, reset;
  logic [31:0] bar_addr, bar_wdata, bar_rdata;
  logic        bar_wen, bar_ren, uart_rx_out, uart_tx_in, irq;

  int tests_run    = 0;
  int tests_failed = 0;

  uart_bar_bridge #(.CLK_DIV(8), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .bar_addr   (bar_addr),
    .bar_wdata  (bar_wdata),
    .bar_wen    (bar_wen),
    .bar_ren    (bar_ren),
    .bar_rdata  (bar_rdata),
    .uart_rx_out(uart_rx_out),
    .uart_tx_in (uart_tx_in),
    .irq        (irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic bar_write(input logic [31:0] a, input logic [31:0] d);
    bar_addr  = a;
    bar_wdata = d;
    bar_wen   = 1'b1;
    tick(1);
    bar_wen   = 1'b0;
  endtask

  task automatic bar_read(input logic [31:0] a, output logic [31:0] d);
    bar_addr = a;
    bar_ren  = 1'b1;
    tick(1);
    bar_ren  = 1'b0;
    d = bar_rdata;
  endtask

  // Drive one 8N1 frame onto uart_tx_in, 8 cycles per bit.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    uart_tx_in = 1'b0;
    tick(8);
    for (int i = 0; i < 8; i++) begin
      uart_tx_in = b[i];
      tick(8);
    end
    uart_tx_in = stop_bit;
    tick(8);
    uart_tx_in = 1'b1;
  endtask

  // Called while the start bit is on the line; checks all 80 cycles of the
  // frame and, optionally, that STATUS reports tx_busy on each of them.
  task automatic expect_frame(input logic [7:0] b, input bit with_status, input string tag);
    logic [9:0] exp_bits;
    logic [9:0] got_bits;
    int         bad_cycles;
    logic       busy_ok;
    exp_bits   = {1'b1, b, 1'b0};
    got_bits   = '0;
    bad_cycles = 0;
    busy_ok    = 1'b1;
    if (with_status) begin
      bar_addr = STATUS;
      bar_ren  = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 8; c++) begin
        if (c == 4) got_bits[i] = uart_rx_out;
        if (uart_rx_out !== exp_bits[i]) bad_cycles++;
        tick(1);
        if (with_status && bar_rdata[7] !== 1'b1) busy_ok = 1'b0;
      end
    end
    bar_ren = 1'b0;
    check({tag, "_bits"}, 32'(got_bits), 32'(exp_bits));
    check({tag, "_cycles"}, bad_cycles, 0);
    if (with_status) check({tag, "_busy"}, 32'(busy_ok), 32'h1);
  endtask

  logic [31:0] rd;
  int          lows;
  logic [7:0]  tx_bytes [6];

  initial begin
    reset      = 1'b1;
    bar_addr   = '0;
    bar_wdata  = '0;
    bar_wen    = 1'b0;
    bar_ren    = 1'b0;
    uart_tx_in = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(4);

    // Reset state
    check("rst_rdata", bar_rdata, 32'h0);
    check("rst_line", 32'(uart_rx_out), 32'h1);
    check("rst_irq", 32'(irq), 32'h0);
    bar_read(STATUS, rd);
    check("rst_status", rd, 32'h0000_0006);

    // TX 0xA5: line still high 1 cycle after the write, start bit after 2
    bar_write(TXDATA, 32'h0000_00A5);
    check("tx_a5_latency", 32'(uart_rx_out), 32'h1);
    tick(1);
    expect_frame(8'hA5, 1'b1, "tx_a5");
    bar_read(STATUS, rd);
    check("tx_a5_status_after", rd, 32'h0000_0006);

    // RX one frame 0x3C
    send_frame(8'h3C, 1'b1);
    tick(2);
    check("rx_3c_irq", 32'(irq), 32'h1);
    bar_read(RXDATA, rd);
    check("rx_3c_data", rd, 32'h0000_013C);
    bar_read(RXDATA, rd);
    check("rx_empty_read", rd, 32'h0);
    check("rx_irq_drop", 32'(irq), 32'h0);

    // RX overrun: 5 frames into a 4-deep FIFO
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1);
    tick(2);
    bar_read(STATUS, rd);
    check("rx_ovr_status", rd, 32'h0000_041A);
    for (int k = 1; k <= 4; k++) begin
      bar_read(RXDATA, rd);
      check($sformatf("rx_ovr_data%0d", k), rd, 32'h100 | 32'(k));
    end
    bar_write(CTRL, 32'h1);
    bar_read(STATUS, rd);
    check("rx_ovr_cleared", rd, 32'h0000_0006);

    // Framing error, then a short glitch
    send_frame(8'h77, 1'b0);
    tick(4);
    bar_read(STATUS, rd);
    check("rx_frame_err", rd, 32'h0000_0026);
    check("rx_frame_irq", 32'(irq), 32'h1);
    bar_write(CTRL, 32'h1);
    uart_tx_in = 1'b0;
    tick(3);
    uart_tx_in = 1'b1;
    tick(30);
    bar_read(STATUS, rd);
    check("rx_glitch_status", rd, 32'h0000_0006);

    // Unmapped address and CTRL read-back
    bar_read(32'h0000_3000, rd);
    check("unmapped_read", rd, 32'hDEAD_BEEF);
`ifdef UART_LOOPBACK_EN
    bar_write(CTRL, 32'h2);
    bar_read(CTRL, rd);
    check("lb_ctrl_read", rd, 32'h2);
    bar_write(TXDATA, 32'h0000_005A);
    lows = 0;
    for (int i = 0; i < 120; i++) begin
      if (uart_rx_out !== 1'b1) lows++;
      tick(1);
    end
    check("lb_line_high", lows, 0);
    bar_read(RXDATA, rd);
    check("lb_rxdata", rd, 32'h0000_015A);
    bar_write(CTRL, 32'h0);
`else
    bar_write(CTRL, 32'h2);
    bar_read(CTRL, rd);
    check("ctrl_read", rd, 32'h0);
`endif

    // TX overflow: 6 back-to-back writes, 5 frames on the line
    tx_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    fork
      begin
        for (int k = 0; k < 6; k++) bar_write(TXDATA, 32'(tx_bytes[k]));
      end
      begin
        tick(2);
        for (int f = 0; f < 5; f++) expect_frame(tx_bytes[f], 1'b0, $sformatf("tx_ovf_f%0d", f));
      end
    join
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      if (uart_rx_out !== 1'b1) lows++;
      tick(1);
    end
    check("tx_ovf_no_sixth", lows, 0);
    bar_read(STATUS, rd);
    check("tx_ovf_status", rd, 32'h0000_0046);

    // Reset in the middle of a frame of zeros
    bar_write(TXDATA, 32'h0000_0000);
    tick(20);
    check("mid_frame_low", 32'(uart_rx_out), 32'h0);
    #3;
    reset = 1'b1;
    #1;
    check("reset_line_high", 32'(uart_rx_out), 32'h1);
    check("reset_irq_low", 32'(irq), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(2);
    check("reset_rdata", bar_rdata, 32'h0);
    bar_read(STATUS, rd);
    check("reset_status", rd, 32'h0000_0006);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      if (uart_rx_out !== 1'b1) lows++;
      tick(1);
    end
    check("reset_line_idle", lows, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
